// File: rtl/dvp_rgb565_cap_if.sv
// Bundles the DVP camera byte bus and the RGB888 output stream of the
// capture front end.
//   master : camera / sensor model side - drives cam_*, observes the stream.
//   slave  : capture block side - samples cam_*, drives post_* and status pulses.
//   cam_vsync/cam_href/cam_data : raw camera bus (high byte of a pixel first)
//   post_vs/post_de/post_data   : aligned VSYNC, pixel strobe, {R,G,B} pixel
//   line_err/frame_err/frame_done : one-cycle geometry / frame status pulses
interface dvp_rgb565_cap_if;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        post_vs;
    logic        post_de;
    logic [23:0] post_data;
    logic        line_err;
    logic        frame_err;
    logic        frame_done;

    modport master (
        output cam_vsync, cam_href, cam_data,
        input  post_vs, post_de, post_data, line_err, frame_err, frame_done
    );

    modport slave (
        input  cam_vsync, cam_href, cam_data,
        output post_vs, post_de, post_data, line_err, frame_err, frame_done
    );
endinterface

// File: rtl/dvp_rgb565_cap.sv
// DVP RGB565 capture front end.
// Registers the camera bus, pairs bytes into RGB565 pixels, expands them to
// RGB888 by MSB replication and emits them as a strobed stream. After the
// first enable following reset, SKIP_FRAMES frames are discarded while the
// sensor settles. Line and frame geometry are checked against H_DISP/V_DISP.
// Ports:
//   pre_clk  : camera pixel clock, the only clock
//   rst      : synchronous active-high reset
//   EN       : capture enable (level)
//   post_clk : copy of pre_clk for the downstream stage
//   bus      : camera bus in, pixel stream and status pulses out
module dvp_rgb565_cap #(
    parameter logic [11:0] H_DISP      = 12'd1280,
    parameter logic [10:0] V_DISP      = 11'd720,
    parameter logic [3:0]  SKIP_FRAMES = 4'd10
) (
    input  logic             pre_clk,
    input  logic             rst,
    input  logic             EN,
    output logic             post_clk,
    dvp_rgb565_cap_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_WAIT_VS, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic        vs_d1_q, vs_d1_d, vs_d2_q, vs_d2_d;
    logic        href_d1_q, href_d1_d, href_d2_q, href_d2_d;
    logic [7:0]  data_d1_q, data_d1_d;
    logic [3:0]  skip_cnt_q, skip_cnt_d;
    logic        skip_done_q, skip_done_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        post_de_q, post_de_d;
    logic [23:0] post_data_q, post_data_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    logic        frame_done_q, frame_done_d;

    logic        vs_pedge, href_nedge;
    logic [10:0] v_cnt_inc;
    logic [15:0] px;
    logic [23:0] rgb888;

    assign vs_pedge   = vs_d1_q & ~vs_d2_q;
    assign href_nedge = ~href_d1_q & href_d2_q;
    assign v_cnt_inc  = (v_cnt_q == 11'h7FF) ? v_cnt_q : v_cnt_q + 11'd1;

    // High byte was latched one cycle earlier; low byte is on data_d1 now.
    assign px     = {hi_q, data_d1_q};
    assign rgb888 = {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};

    always_comb begin
        state_d      = state_q;
        vs_d1_d      = bus.cam_vsync;
        vs_d2_d      = vs_d1_q;
        href_d1_d    = bus.cam_href;
        href_d2_d    = href_d1_q;
        data_d1_d    = bus.cam_data;
        skip_cnt_d   = skip_cnt_q;
        skip_done_d  = skip_done_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        post_de_d    = 1'b0;
        post_data_d  = post_data_q;
        line_err_d   = 1'b0;
        frame_err_d  = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                skip_cnt_d = 4'd0;
                phase_d    = 1'b0;
                if (EN) begin
                    // Settling skip happens only once per reset.
                    if (skip_done_q || (SKIP_FRAMES == 4'd0)) state_d = ST_WAIT_VS;
                    else                                      state_d = ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (skip_cnt_q == SKIP_FRAMES) begin
                    state_d     = ST_WAIT_VS;
                    skip_done_d = 1'b1;
                end else if (vs_pedge) begin
                    skip_cnt_d = skip_cnt_q + 4'd1;
                end
            end
            ST_WAIT_VS: begin
                if (vs_pedge) begin
                    state_d = ST_RUN;
                    h_cnt_d = 12'd0;
                    v_cnt_d = 11'd0;
                    phase_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (href_d1_q) begin
                    if (!phase_q) begin
                        hi_d    = data_d1_q;
                        phase_d = 1'b1;
                    end else begin
                        post_data_d = rgb888;
                        post_de_d   = 1'b1;
                        phase_d     = 1'b0;
                        h_cnt_d     = (h_cnt_q == 12'hFFF) ? h_cnt_q : h_cnt_q + 12'd1;
                    end
                end else begin
                    // A dangling high byte at line end is dropped here.
                    phase_d = 1'b0;
                end
                if (href_nedge) begin
                    line_err_d = (h_cnt_q != H_DISP) || phase_q;
                    v_cnt_d    = v_cnt_inc;
                    h_cnt_d    = 12'd0;
                end
                if (vs_pedge) begin
                    frame_done_d = 1'b1;
                    // A line ending on the same cycle is counted before the check.
                    frame_err_d  = (href_nedge ? v_cnt_inc : v_cnt_q) != V_DISP;
                    v_cnt_d      = 11'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disable wins over everything: no pixel, no pulses, back to IDLE.
        if (!EN) begin
            state_d      = ST_IDLE;
            post_de_d    = 1'b0;
            post_data_d  = post_data_q;
            line_err_d   = 1'b0;
            frame_err_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge pre_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vs_d1_q      <= 1'b0;
            vs_d2_q      <= 1'b0;
            href_d1_q    <= 1'b0;
            href_d2_q    <= 1'b0;
            data_d1_q    <= 8'd0;
            skip_cnt_q   <= 4'd0;
            skip_done_q  <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= 8'd0;
            h_cnt_q      <= 12'd0;
            v_cnt_q      <= 11'd0;
            post_de_q    <= 1'b0;
            post_data_q  <= 24'd0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_d1_q      <= vs_d1_d;
            vs_d2_q      <= vs_d2_d;
            href_d1_q    <= href_d1_d;
            href_d2_q    <= href_d2_d;
            data_d1_q    <= data_d1_d;
            skip_cnt_q   <= skip_cnt_d;
            skip_done_q  <= skip_done_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            post_de_q    <= post_de_d;
            post_data_q  <= post_data_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign post_clk       = pre_clk;
    assign bus.post_vs    = vs_d2_q;
    assign bus.post_de    = post_de_q;
    assign bus.post_data  = post_data_q;
    assign bus.line_err   = line_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_dvp_rgb565_cap.sv
// Self-checking bench for dvp_rgb565_cap with a small geometry
// (4x2 pixels, 2 skipped frames). Expected pixels and their arrival cycle are
// queued when the second byte is driven and checked when post_de appears.
module tb_dvp_rgb565_cap;
    localparam logic [11:0] H = 12'd4;
    localparam logic [10:0] V = 11'd2;
    localparam logic [3:0]  S = 4'd2;

    typedef struct {
        logic [23:0] data;
        int          cyc;
    } exp_t;

    logic pre_clk = 1'b0;
    logic rst     = 1'b1;
    logic EN      = 1'b0;
    logic post_clk;

    dvp_rgb565_cap_if bus();

    dvp_rgb565_cap #(.H_DISP(H), .V_DISP(V), .SKIP_FRAMES(S)) dut (
        .pre_clk  (pre_clk),
        .rst      (rst),
        .EN       (EN),
        .post_clk (post_clk),
        .bus      (bus)
    );

    always #5 pre_clk = ~pre_clk;

    int   cyc = 0;
    always @(posedge pre_clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [7:0] line_bytes [0:15];
    int   de_cnt = 0, le_cnt = 0, fe_cnt = 0, fd_cnt = 0, both_cnt = 0;
    logic prev_de = 1'b0;

    // Output monitor: scoreboard pops and pulse counters.
    always @(negedge pre_clk) begin
        if (rst) begin
            prev_de = 1'b0;
        end else begin
            if (bus.post_de) begin
                de_cnt++;
                checks++;
                if (prev_de) begin
                    errors++;
                    $display("FAIL de_spacing: post_de high on consecutive cycles at cycle %0d, required a gap", cyc);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel: got data=%h at cycle %0d, required no pixel", bus.post_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.post_data !== mon_e.data || cyc !== mon_e.cyc) begin
                        errors++;
                        $display("FAIL pixel: got data=%h cycle=%0d, required data=%h cycle=%0d",
                                 bus.post_data, cyc, mon_e.data, mon_e.cyc);
                    end
                end
            end
            prev_de = bus.post_de;
            if (bus.line_err)   le_cnt++;
            if (bus.frame_err)  fe_cnt++;
            if (bus.frame_done) fd_cnt++;
            if (bus.frame_err && bus.frame_done) both_cnt++;
        end
    end

    function automatic logic [23:0] expand(input logic [15:0] p);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = p[15:11];
        g = p[10:5];
        b = p[4:0];
        return {r, r[4:2], g, g[5:4], b, b[4:2]};
    endfunction

    task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
        bus.cam_vsync = vs;
        bus.cam_href  = hr;
        bus.cam_data  = d;
        @(posedge pre_clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) line_bytes[i] = 8'($urandom);
    endtask

    task automatic send_line(input int n, input bit stream);
        logic [7:0] hi;
        exp_t e;
        hi = 8'h00;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, line_bytes[i]);
            if (i % 2 == 0) begin
                hi = line_bytes[i];
            end else if (stream) begin
                e.data = expand({hi, line_bytes[i]});
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
            end
        end
        repeat (4) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vsync_pulse();
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d pixels missing, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.cam_vsync = 1'b0;
        bus.cam_href  = 1'b0;
        bus.cam_data  = 8'h00;
        rst = 1'b1;
        EN  = 1'b0;
        repeat (3) @(posedge pre_clk);
        #1;
        checks++; if (bus.post_vs !== 1'b0)     begin errors++; $display("FAIL reset_post_vs: got %b, required 0", bus.post_vs); end
        checks++; if (bus.post_de !== 1'b0)     begin errors++; $display("FAIL reset_post_de: got %b, required 0", bus.post_de); end
        checks++; if (bus.post_data !== 24'h0)  begin errors++; $display("FAIL reset_post_data: got %h, required 000000", bus.post_data); end
        checks++; if (bus.line_err !== 1'b0)    begin errors++; $display("FAIL reset_line_err: got %b, required 0", bus.line_err); end
        checks++; if (bus.frame_err !== 1'b0)   begin errors++; $display("FAIL reset_frame_err: got %b, required 0", bus.frame_err); end
        checks++; if (bus.frame_done !== 1'b0)  begin errors++; $display("FAIL reset_frame_done: got %b, required 0", bus.frame_done); end
        checks++; if (post_clk !== 1'b1)        begin errors++; $display("FAIL post_clk_high: got %b, required 1", post_clk); end
        @(negedge pre_clk);
        #1;
        checks++; if (post_clk !== 1'b0)        begin errors++; $display("FAIL post_clk_low: got %b, required 0", post_clk); end
        @(posedge pre_clk);
        #1;
        rst = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_skip();
        int d0, fd0, fe0, le0;
        EN = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        fd0 = fd_cnt; fe0 = fe_cnt; le0 = le_cnt;
        for (int f = 0; f < 4; f++) begin
            vsync_pulse();
            d0 = de_cnt;
            for (int l = 0; l < 2; l++) begin
                fill_random();
                send_line(8, f >= 2);
            end
            checks++;
            if (de_cnt - d0 !== ((f >= 2) ? 8 : 0)) begin
                errors++;
                $display("FAIL skip_frame%0d_pixels: got %0d, required %0d", f + 1, de_cnt - d0, (f >= 2) ? 8 : 0);
            end
        end
        vsync_pulse();
        checks++; if (fd_cnt - fd0 !== 2) begin errors++; $display("FAIL skip_frame_done: got %0d, required 2", fd_cnt - fd0); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL skip_frame_err: got %0d, required 0", fe_cnt - fe0); end
        checks++; if (le_cnt - le0 !== 0) begin errors++; $display("FAIL skip_line_err: got %0d, required 0", le_cnt - le0); end
        check_drained("skip");
    endtask

    task automatic test_conversion();
        int fd0, fe0;
        logic [7:0] tab [0:7];
        tab = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'h84, 8'h10};
        fd0 = fd_cnt; fe0 = fe_cnt;
        for (int i = 0; i < 8; i++) line_bytes[i] = tab[i];
        send_line(8, 1'b1);
        fill_random();
        send_line(8, 1'b1);
        // Frame end with post_vs alignment: two cycles behind the bus.
        drive(1'b1, 1'b0, 8'h00);
        checks++; if (bus.post_vs !== 1'b0) begin errors++; $display("FAIL vs_lag_rise1: got %b, required 0", bus.post_vs); end
        drive(1'b1, 1'b0, 8'h00);
        checks++; if (bus.post_vs !== 1'b1) begin errors++; $display("FAIL vs_lag_rise2: got %b, required 1", bus.post_vs); end
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        checks++; if (bus.post_vs !== 1'b1) begin errors++; $display("FAIL vs_lag_fall1: got %b, required 1", bus.post_vs); end
        drive(1'b0, 1'b0, 8'h00);
        checks++; if (bus.post_vs !== 1'b0) begin errors++; $display("FAIL vs_lag_fall2: got %b, required 0", bus.post_vs); end
        drive(1'b0, 1'b0, 8'h00);
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL conv_frame_done: got %0d, required 1", fd_cnt - fd0); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL conv_frame_err: got %0d, required 0", fe_cnt - fe0); end
        check_drained("conv");
    endtask

    task automatic test_short_line();
        int le0, fd0, fe0;
        fd0 = fd_cnt; fe0 = fe_cnt;
        le0 = le_cnt;
        fill_random();
        send_line(6, 1'b1);
        checks++; if (le_cnt - le0 !== 1) begin errors++; $display("FAIL short_line_err: got %0d, required 1", le_cnt - le0); end
        le0 = le_cnt;
        fill_random();
        send_line(7, 1'b1);
        checks++; if (le_cnt - le0 !== 1) begin errors++; $display("FAIL odd_line_err: got %0d, required 1", le_cnt - le0); end
        vsync_pulse();
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL short_frame_done: got %0d, required 1", fd_cnt - fd0); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL short_frame_err: got %0d, required 0", fe_cnt - fe0); end
        check_drained("short");
    endtask

    task automatic test_frame_geometry();
        int fd0, fe0, b0, le0;
        fd0 = fd_cnt; fe0 = fe_cnt; b0 = both_cnt; le0 = le_cnt;
        for (int l = 0; l < 3; l++) begin
            fill_random();
            send_line(8, 1'b1);
        end
        vsync_pulse();
        checks++; if (fe_cnt - fe0 !== 1)   begin errors++; $display("FAIL tall_frame_err: got %0d, required 1", fe_cnt - fe0); end
        checks++; if (fd_cnt - fd0 !== 1)   begin errors++; $display("FAIL tall_frame_done: got %0d, required 1", fd_cnt - fd0); end
        checks++; if (both_cnt - b0 !== 1)  begin errors++; $display("FAIL tall_together: got %0d, required 1", both_cnt - b0); end
        checks++; if (le_cnt - le0 !== 0)   begin errors++; $display("FAIL tall_line_err: got %0d, required 0", le_cnt - le0); end
        fd0 = fd_cnt; fe0 = fe_cnt;
        for (int l = 0; l < 2; l++) begin
            fill_random();
            send_line(8, 1'b1);
        end
        vsync_pulse();
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL good_frame_err: got %0d, required 0", fe_cnt - fe0); end
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL good_frame_done: got %0d, required 1", fd_cnt - fd0); end
        check_drained("geom");
    endtask

    task automatic test_en_toggle();
        int d0, le0, fe0, fd0;
        bit de_seen;
        fill_random();
        d0 = de_cnt; le0 = le_cnt; fe0 = fe_cnt; fd0 = fd_cnt;
        drive(1'b0, 1'b1, line_bytes[0]);
        drive(1'b0, 1'b1, line_bytes[1]);
        EN = 1'b0;
        de_seen = 1'b0;
        for (int i = 2; i < 8; i++) begin
            drive(1'b0, 1'b1, line_bytes[i]);
            if (bus.post_de !== 1'b0) de_seen = 1'b1;
        end
        checks++; if (de_seen) begin errors++; $display("FAIL en_drop_de: got post_de=1 after disable, required 0"); end
        repeat (4) drive(1'b0, 1'b0, 8'h00);
        vsync_pulse();
        fill_random();
        send_line(8, 1'b0);
        checks++; if (de_cnt - d0 !== 0) begin errors++; $display("FAIL en_off_pixels: got %0d, required 0", de_cnt - d0); end
        checks++; if (le_cnt + fe_cnt + fd_cnt - le0 - fe0 - fd0 !== 0) begin
            errors++; $display("FAIL en_off_pulses: got %0d, required 0", le_cnt + fe_cnt + fd_cnt - le0 - fe0 - fd0);
        end
        EN = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        fill_random();
        send_line(8, 1'b0);
        checks++; if (de_cnt - d0 !== 0) begin errors++; $display("FAIL en_wait_pixels: got %0d, required 0", de_cnt - d0); end
        vsync_pulse();
        fd0 = fd_cnt; fe0 = fe_cnt;
        for (int l = 0; l < 2; l++) begin
            fill_random();
            send_line(8, 1'b1);
        end
        vsync_pulse();
        checks++; if (de_cnt - d0 !== 8) begin errors++; $display("FAIL en_resume_pixels: got %0d, required 8", de_cnt - d0); end
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL en_resume_done: got %0d, required 1", fd_cnt - fd0); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL en_resume_err: got %0d, required 0", fe_cnt - fe0); end
        check_drained("en");
    endtask

    task automatic test_reset_midframe();
        int d0;
        fill_random();
        drive(1'b0, 1'b1, line_bytes[0]);
        drive(1'b0, 1'b1, line_bytes[1]);
        rst = 1'b1;
        drive(1'b0, 1'b1, line_bytes[2]);
        checks++; if (bus.post_de !== 1'b0)    begin errors++; $display("FAIL midrst_post_de: got %b, required 0", bus.post_de); end
        checks++; if (bus.post_data !== 24'h0) begin errors++; $display("FAIL midrst_post_data: got %h, required 000000", bus.post_data); end
        rst = 1'b0;
        repeat (4) drive(1'b0, 1'b0, 8'h00);
        d0 = de_cnt;
        for (int f = 0; f < 2; f++) begin
            vsync_pulse();
            fill_random();
            send_line(8, 1'b0);
        end
        checks++; if (de_cnt - d0 !== 0) begin errors++; $display("FAIL midrst_skip: got %0d pixels, required 0", de_cnt - d0); end
        check_drained("midrst");
    endtask

    initial begin
        test_reset();
        test_skip();
        test_conversion();
        test_short_line();
        test_frame_geometry();
        test_en_toggle();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
